// File: rtl/addsub_arbiter.sv
// Round-robin arbiter that time-shares one registered 8-bit add/sub unit
// between NREQ requesters, returning each result with a one-hot valid pulse.

module addsub (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic       iOp,
  input  logic [7:0] iA,
  input  logic [7:0] iB,
  output logic [7:0] oRes
);
  // Carry/borrow are dropped: plain 8-bit modulo arithmetic.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) oRes <= 8'h00;
    else      oRes <= iOp ? (iA - iB) : (iA + iB);
  end
endmodule

module addsub_arbiter #(
  parameter int NREQ = 2,
  parameter int CNTW = 16
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic [NREQ-1:0]   iREQ,
  input  logic [NREQ-1:0]   iOPCODE,
  input  logic [NREQ*8-1:0] iDATAIN1,
  input  logic [NREQ*8-1:0] iDATAIN2,
  output logic [NREQ-1:0]   oGNT,
  output logic [NREQ-1:0]   oVALID,
  output logic [7:0]        oDATAOUT,
  output logic              oBUSY,
  output logic [CNTW-1:0]   oOPCNT
);
  localparam int LW = $clog2(NREQ);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;

  logic [1:0]    state;
  logic [LW-1:0] last, win;
  logic          opReg;
  logic [7:0]    aReg, bReg, aluRes;

  addsub uAlu (
    .iCLK (iCLK),
    .iRST (iRST),
    .iOp  (opReg),
    .iA   (aReg),
    .iB   (bReg),
    .oRes (aluRes)
  );

  // Winner search starts just after the last grant, wrapping mod NREQ.
  always_comb begin
    logic          found;
    int            idx;
    logic [LW-1:0] idxL;
    win   = last;
    found = 1'b0;
    idx   = 0;
    idxL  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = int'(last) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      idxL = LW'(idx);
      if (!found && iREQ[idxL]) begin
        found = 1'b1;
        win   = idxL;
      end
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state    <= IDLE;
      oGNT     <= '0;
      oVALID   <= '0;
      oDATAOUT <= 8'h00;
      oBUSY    <= 1'b0;
      oOPCNT   <= '0;
      last     <= LW'(NREQ - 1);
      opReg    <= 1'b0;
      aReg     <= 8'h00;
      bReg     <= 8'h00;
    end else begin
      oGNT   <= '0;
      oVALID <= '0;
      case (state)
        IDLE: begin
          if (|iREQ) begin
            opReg <= iOPCODE[win];
            aReg  <= iDATAIN1[8*win +: 8];
            bReg  <= iDATAIN2[8*win +: 8];
            last  <= win;
            oGNT  <= NREQ'(1) << win;
            oBUSY <= 1'b1;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          oBUSY <= 1'b1;
          state <= RESP;
        end
        RESP: begin
          // last still holds the requester whose op is in flight.
          oDATAOUT <= aluRes;
          oVALID   <= NREQ'(1) << last;
          oOPCNT   <= oOPCNT + CNTW'(1);
          oBUSY    <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          oBUSY <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed bench for addsub_arbiter (NREQ=2, CNTW=4): single-op vector table
// plus contention, late-request, mid-op reset and counter-wrap sequences.

module tb_addsub_arbiter;
  localparam int NREQ = 2;
  localparam int CNTW = 4;

  logic              iCLK = 1'b0;
  logic              iRST;
  logic [NREQ-1:0]   iREQ;
  logic [NREQ-1:0]   iOPCODE;
  logic [NREQ*8-1:0] iDATAIN1, iDATAIN2;
  logic [NREQ-1:0]   oGNT, oVALID;
  logic [7:0]        oDATAOUT;
  logic              oBUSY;
  logic [CNTW-1:0]   oOPCNT;

  int errors = 0;
  int checks = 0;
  int expCnt = 0;

  addsub_arbiter #(.NREQ(NREQ), .CNTW(CNTW)) dut (
    .iCLK(iCLK), .iRST(iRST), .iREQ(iREQ), .iOPCODE(iOPCODE),
    .iDATAIN1(iDATAIN1), .iDATAIN2(iDATAIN2), .oGNT(oGNT), .oVALID(oVALID),
    .oDATAOUT(oDATAOUT), .oBUSY(oBUSY), .oOPCNT(oOPCNT)
  );

  always #5 iCLK = ~iCLK;

  typedef struct {
    int         r;
    logic       op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge iCLK);
    #1;
  endtask

  // Grant and valid must never share a cycle.
  always @(negedge iCLK) begin
    if (!iRST) begin
      checks++;
      if ((|oGNT) && (|oVALID)) begin
        errors++;
        $display("FAIL overlap: gnt=%b valid=%b at %0t", oGNT, oVALID, $time);
      end
    end
  end

  task automatic runVec(input vec_t v);
    logic [NREQ-1:0] oh;
    oh = NREQ'(1) << v.r;
    iREQ     = oh;
    iOPCODE  = {NREQ{~v.op}};
    iOPCODE[v.r] = v.op;
    iDATAIN1 = {NREQ{8'hA5}};
    iDATAIN2 = {NREQ{8'h5A}};
    iDATAIN1[8*v.r +: 8] = v.a;
    iDATAIN2[8*v.r +: 8] = v.b;
    step();
    check("vec_gnt", 32'(oGNT), 32'(oh));
    check("vec_busy_issue", 32'(oBUSY), 1);
    iREQ = '0;
    iDATAIN1 = '1;
    iDATAIN2 = '1;
    iOPCODE  = ~iOPCODE;
    step();
    check("vec_gnt_clear", 32'(oGNT), 0);
    check("vec_no_early_valid", 32'(oVALID), 0);
    step();
    expCnt = (expCnt + 1) % 16;
    check("vec_valid", 32'(oVALID), 32'(oh));
    check("vec_data", 32'(oDATAOUT), 32'(v.res));
    check("vec_busy_done", 32'(oBUSY), 0);
    check("vec_cnt", 32'(oOPCNT), 32'(expCnt));
  endtask

  initial begin
    vecs[0] = '{0, 1'b0, 8'h12, 8'h34, 8'h46};
    vecs[1] = '{1, 1'b1, 8'h00, 8'h01, 8'hFF};
    vecs[2] = '{0, 1'b0, 8'hFF, 8'h01, 8'h00};
    vecs[3] = '{1, 1'b0, 8'h80, 8'h80, 8'h00};
    vecs[4] = '{0, 1'b1, 8'h50, 8'h20, 8'h30};
    vecs[5] = '{1, 1'b1, 8'h10, 8'h20, 8'hF0};
    vecs[6] = '{0, 1'b0, 8'h7F, 8'h01, 8'h80};
    vecs[7] = '{1, 1'b1, 8'hFF, 8'hFF, 8'h00};

    iRST = 1'b1; iREQ = '0; iOPCODE = '0; iDATAIN1 = '0; iDATAIN2 = '0;
    step(); step();
    check("rst_gnt", 32'(oGNT), 0);
    check("rst_valid", 32'(oVALID), 0);
    check("rst_data", 32'(oDATAOUT), 0);
    check("rst_busy", 32'(oBUSY), 0);
    check("rst_cnt", 32'(oOPCNT), 0);
    iRST = 1'b0;
    step();
    check("idle_busy", 32'(oBUSY), 0);
    check("idle_gnt", 32'(oGNT), 0);

    for (int i = 0; i < 8; i++) runVec(vecs[i]);
    step();
    check("valid_pulse_end", 32'(oVALID), 0);

    // Contention: last grant went to r1, so the held pair alternates 0,1,0,1.
    iREQ = 2'b11; iOPCODE = 2'b10;
    iDATAIN1 = {8'h09, 8'h01};
    iDATAIN2 = {8'h04, 8'h02};
    for (int i = 0; i < 4; i++) begin
      step();
      check("cont_gnt", 32'(oGNT), (i % 2 == 0) ? 1 : 2);
      if (i == 3) iREQ = '0;
      step();
      step();
      expCnt = (expCnt + 1) % 16;
      check("cont_valid", 32'(oVALID), (i % 2 == 0) ? 1 : 2);
      check("cont_data", 32'(oDATAOUT), (i % 2 == 0) ? 32'h03 : 32'h05);
      check("cont_cnt", 32'(oOPCNT), 32'(expCnt));
    end

    // Late request: r1 appears during r0's ISSUE and waits for the next IDLE.
    iREQ = 2'b01; iOPCODE = 2'b10;
    iDATAIN1 = {8'h40, 8'h11};
    iDATAIN2 = {8'h01, 8'h22};
    step();
    check("late_gnt0", 32'(oGNT), 1);
    iREQ = 2'b10;
    step();
    check("late_ignored", 32'(oGNT), 0);
    step();
    expCnt = (expCnt + 1) % 16;
    check("late_valid0", 32'(oVALID), 1);
    check("late_data0", 32'(oDATAOUT), 32'h33);
    check("late_gnt_wait", 32'(oGNT), 0);
    step();
    check("late_gnt1", 32'(oGNT), 2);
    iREQ = '0;
    step();
    step();
    expCnt = (expCnt + 1) % 16;
    check("late_valid1", 32'(oVALID), 2);
    check("late_data1", 32'(oDATAOUT), 32'h3F);
    check("late_cnt", 32'(oOPCNT), 32'(expCnt));

    // Reset while RESP is pending: the op must vanish.
    iREQ = 2'b01; iOPCODE = 2'b00;
    iDATAIN1 = {8'h00, 8'h01};
    iDATAIN2 = {8'h00, 8'h01};
    step();
    iREQ = '0;
    step();
    check("pre_rst_busy", 32'(oBUSY), 1);
    iRST = 1'b1;
    #1;
    check("midrst_valid", 32'(oVALID), 0);
    check("midrst_data", 32'(oDATAOUT), 0);
    check("midrst_cnt", 32'(oOPCNT), 0);
    check("midrst_busy", 32'(oBUSY), 0);
    step();
    check("midrst_valid_hold", 32'(oVALID), 0);
    iRST = 1'b0;
    expCnt = 0;
    step();
    check("post_rst_valid", 32'(oVALID), 0);
    check("post_rst_cnt", 32'(oOPCNT), 0);

    // Counter wrap: 16 ops under contention, pointer reset gives r0 first.
    iREQ = 2'b11; iOPCODE = 2'b10;
    iDATAIN1 = {8'h10, 8'h10};
    iDATAIN2 = {8'h05, 8'h05};
    for (int i = 0; i < 16; i++) begin
      step();
      check("wrap_gnt", 32'(oGNT), (i % 2 == 0) ? 1 : 2);
      if (i == 15) iREQ = '0;
      step();
      step();
      expCnt = (expCnt + 1) % 16;
      check("wrap_valid", 32'(oVALID), (i % 2 == 0) ? 1 : 2);
      check("wrap_data", 32'(oDATAOUT), (i % 2 == 0) ? 32'h15 : 32'h0B);
      check("wrap_cnt", 32'(oOPCNT), 32'(expCnt));
    end
    check("wrap_final_zero", 32'(oOPCNT), 0);
    step();
    check("final_busy", 32'(oBUSY), 0);
    check("final_gnt", 32'(oGNT), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
